// File: rtl/control_unit_exc.sv
// Multicycle MIPS-subset control unit with precise exceptions.
// Covers illegal opcodes, ALU overflow, divide-by-zero and MULT/DIV timeouts; all trap through EXC.
//
// state     | meaning
// FETCH     | read instruction, PC += 4 on the last wait cycle
// DECODE    | register read, branch target into ALUOut, dispatch
// MEM_ADDR  | base + imm for lw/sw
// MEM_READ  | data read, held MEM_WAIT+1 cycles
// LW_WB     | MDR -> rt
// SW_WRITE  | data write, held MEM_WAIT+1 cycles
// R_EXEC    | R-type ALU operation
// I_EXEC    | addi ALU operation
// LUI_EXEC  | lui ALU operation
// WB        | ALUOut -> rd (R-type) or rt
// BRANCH    | beq/bne compare and conditional PC load
// JUMP      | j / jr
// JAL       | $31 = PC, PC = jump target
// MD_START  | start pulse to multiplier or divider
// MD_WAIT   | wait for done with timeout
// MF_WB     | HI/LO -> rd
// EXC       | EPC = PC-4, Cause load, PC = exception vector
module control_unit_exc #(
  parameter int unsigned MEM_WAIT   = 0,
  parameter int unsigned MD_TIMEOUT = 40,
  parameter bit          EXC_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_overflow_in,
  input  logic       mult_done_in,
  input  logic       div_done_in,
  input  logic       div_by_zero_in,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNeg,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       HIWrite,
  output logic       LOWrite,
  output logic       MultStart,
  output logic       DivStart,
  output logic [1:0] RegDst,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [2:0] PCSource,
  output logic [1:0] WBDataSrc,
  output logic       EPCWrite,
  output logic       CauseWrite,
  output logic [2:0] ExcCause
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1100;

  localparam logic [2:0] CAUSE_NONE    = 3'b000;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'b001;
  localparam logic [2:0] CAUSE_OVF     = 3'b010;
  localparam logic [2:0] CAUSE_DIV0    = 3'b011;
  localparam logic [2:0] CAUSE_MD_TMO  = 3'b100;

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_LW_WB, S_SW_WRITE,
    S_R_EXEC, S_I_EXEC, S_LUI_EXEC, S_WB, S_BRANCH, S_JUMP, S_JAL,
    S_MD_START, S_MD_WAIT, S_MF_WB, S_EXC
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [2:0] cause_q;

  logic is_rtype, r_add, r_sub, r_and, r_slt, r_jr, r_mult, r_div, r_mfhi, r_mflo;
  logic mem_last, md_done, md_timeout, div0_trap;

  assign is_rtype = (opcode == OP_RTYPE);
  assign r_add    = is_rtype && (funct == FN_ADD);
  assign r_sub    = is_rtype && (funct == FN_SUB);
  assign r_and    = is_rtype && (funct == FN_AND);
  assign r_slt    = is_rtype && (funct == FN_SLT);
  assign r_jr     = is_rtype && (funct == FN_JR);
  assign r_mult   = is_rtype && (funct == FN_MULT);
  assign r_div    = is_rtype && (funct == FN_DIV);
  assign r_mfhi   = is_rtype && (funct == FN_MFHI);
  assign r_mflo   = is_rtype && (funct == FN_MFLO);

  // One shared counter times memory waits and the MULT/DIV watchdog; it is cleared on every state change.
  assign mem_last   = (wait_cnt == 8'(MEM_WAIT));
  assign md_timeout = (wait_cnt == 8'(MD_TIMEOUT - 1));
  assign md_done    = r_mult ? mult_done_in : div_done_in;
  assign div0_trap  = EXC_ENABLE && r_div && div_by_zero_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      wait_cnt <= '0;
      unique case (state)
        S_FETCH: begin
          if (mem_last) state <= S_DECODE;
          else          wait_cnt <= wait_cnt + 8'd1;
        end
        S_DECODE: begin
          if (opcode == OP_LW || opcode == OP_SW)       state <= S_MEM_ADDR;
          else if (opcode == OP_ADDI)                   state <= S_I_EXEC;
          else if (opcode == OP_LUI)                    state <= S_LUI_EXEC;
          else if (opcode == OP_BEQ || opcode == OP_BNE) state <= S_BRANCH;
          else if (opcode == OP_J)                      state <= S_JUMP;
          else if (opcode == OP_JAL)                    state <= S_JAL;
          else if (r_add || r_sub || r_and || r_slt)    state <= S_R_EXEC;
          else if (r_jr)                                state <= S_JUMP;
          else if (r_mult || r_div)                     state <= S_MD_START;
          else if (r_mfhi || r_mflo)                    state <= S_MF_WB;
          else if (EXC_ENABLE) begin
            state   <= S_EXC;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            state <= S_FETCH;
          end
        end
        S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_READ : S_SW_WRITE;
        S_MEM_READ: begin
          if (mem_last) state <= S_LW_WB;
          else          wait_cnt <= wait_cnt + 8'd1;
        end
        S_SW_WRITE: begin
          if (mem_last) state <= S_FETCH;
          else          wait_cnt <= wait_cnt + 8'd1;
        end
        S_R_EXEC: begin
          if (EXC_ENABLE && alu_overflow_in && (r_add || r_sub)) begin
            state   <= S_EXC;
            cause_q <= CAUSE_OVF;
          end else begin
            state <= S_WB;
          end
        end
        S_I_EXEC: begin
          if (EXC_ENABLE && alu_overflow_in) begin
            state   <= S_EXC;
            cause_q <= CAUSE_OVF;
          end else begin
            state <= S_WB;
          end
        end
        S_LUI_EXEC: state <= S_WB;
        S_MD_START: begin
          if (div0_trap) begin
            state   <= S_EXC;
            cause_q <= CAUSE_DIV0;
          end else begin
            state <= S_MD_WAIT;
          end
        end
        S_MD_WAIT: begin
          // A done arriving on the timeout cycle still completes the operation.
          if (md_done) begin
            state <= S_FETCH;
          end else if (md_timeout) begin
            if (EXC_ENABLE) begin
              state   <= S_EXC;
              cause_q <= CAUSE_MD_TMO;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_LW_WB, S_WB, S_BRANCH, S_JUMP, S_JAL, S_MF_WB, S_EXC: state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite        = 1'b0;
    PCWriteCond    = 1'b0;
    PCWriteCondNeg = 1'b0;
    IorD           = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    IRWrite        = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = 1'b1;
    HIWrite        = 1'b0;
    LOWrite        = 1'b0;
    MultStart      = 1'b0;
    DivStart       = 1'b0;
    RegDst         = 2'b00;
    ALUSrcB        = 2'b00;
    ALUOp          = 4'b0000;
    PCSource       = 3'b000;
    WBDataSrc      = 2'b00;
    EPCWrite       = 1'b0;
    CauseWrite     = 1'b0;
    ExcCause       = CAUSE_NONE;
    unique case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        PCWrite = mem_last;
        IRWrite = mem_last;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUOp   = ALU_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        ALUSrcB = 2'b10;
        ALUOp   = ALU_ADD;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_SW_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_LW_WB: begin
        RegWrite  = 1'b1;
        WBDataSrc = 2'b01;
      end
      S_R_EXEC: begin
        if (r_sub)      ALUOp = ALU_SUB;
        else if (r_and) ALUOp = ALU_AND;
        else if (r_slt) ALUOp = ALU_SLT;
        else            ALUOp = ALU_ADD;
      end
      S_LUI_EXEC: begin
        ALUSrcB = 2'b10;
        ALUOp   = ALU_LUI;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = is_rtype ? 2'b01 : 2'b00;
      end
      S_BRANCH: begin
        ALUOp          = ALU_SUB;
        PCSource       = 3'b001;
        PCWriteCond    = (opcode == OP_BEQ);
        PCWriteCondNeg = (opcode == OP_BNE);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = r_jr ? 3'b011 : 3'b010;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        PCSource = 3'b010;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b01;
      end
      S_MD_START: begin
        MultStart = r_mult;
        DivStart  = r_div && !div0_trap;
      end
      S_MD_WAIT: begin
        HIWrite = md_done;
        LOWrite = md_done;
      end
      S_MF_WB: begin
        RegWrite  = 1'b1;
        RegDst    = 2'b01;
        WBDataSrc = r_mflo ? 2'b11 : 2'b10;
      end
      S_EXC: begin
        EPCWrite   = 1'b1;
        CauseWrite = 1'b1;
        ExcCause   = cause_q;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b01;
        ALUOp      = ALU_SUB;
        PCWrite    = 1'b1;
        PCSource   = 3'b100;
      end
      default: begin
        ALUSrcA = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit_exc.sv
// Bench for control_unit_exc: per-cycle expected control words queued as stimulus is applied.
// Instance a: MEM_WAIT=2, MD_TIMEOUT=8, traps on. Instance b: MEM_WAIT=0, MD_TIMEOUT=8, traps off.
module tb_control_unit_exc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [5:0] opcode, funct;
  logic       alu_overflow_in, mult_done_in, div_done_in, div_by_zero_in;

  typedef struct packed {
    logic       pc_write, pc_write_cond, pc_write_cond_neg, ior_d, mem_read, mem_write, ir_write;
    logic       reg_write, alu_src_a, hi_write, lo_write, mult_start, div_start;
    logic [1:0] reg_dst, alu_src_b;
    logic [3:0] alu_op;
    logic [2:0] pc_source;
    logic [1:0] wb_data_src;
    logic       epc_write, cause_write;
    logic [2:0] exc_cause;
  } ctrl_t;

  logic a_pcw, a_pcc, a_pcn, a_iord, a_mr, a_mw, a_irw, a_rw, a_asa, a_hiw, a_low, a_ms, a_ds;
  logic [1:0] a_rd, a_asb, a_wbs;
  logic [3:0] a_op;
  logic [2:0] a_pcs, a_ec;
  logic a_epc, a_cw;
  logic b_pcw, b_pcc, b_pcn, b_iord, b_mr, b_mw, b_irw, b_rw, b_asa, b_hiw, b_low, b_ms, b_ds;
  logic [1:0] b_rd, b_asb, b_wbs;
  logic [3:0] b_op;
  logic [2:0] b_pcs, b_ec;
  logic b_epc, b_cw;
  ctrl_t out_a, out_b;

  assign out_a = '{a_pcw, a_pcc, a_pcn, a_iord, a_mr, a_mw, a_irw, a_rw, a_asa, a_hiw, a_low,
                   a_ms, a_ds, a_rd, a_asb, a_op, a_pcs, a_wbs, a_epc, a_cw, a_ec};
  assign out_b = '{b_pcw, b_pcc, b_pcn, b_iord, b_mr, b_mw, b_irw, b_rw, b_asa, b_hiw, b_low,
                   b_ms, b_ds, b_rd, b_asb, b_op, b_pcs, b_wbs, b_epc, b_cw, b_ec};

  control_unit_exc #(.MEM_WAIT(2), .MD_TIMEOUT(8), .EXC_ENABLE(1'b1)) dut_a (
    .clk(clk), .reset(rst_a), .opcode(opcode), .funct(funct),
    .alu_overflow_in(alu_overflow_in), .mult_done_in(mult_done_in),
    .div_done_in(div_done_in), .div_by_zero_in(div_by_zero_in),
    .PCWrite(a_pcw), .PCWriteCond(a_pcc), .PCWriteCondNeg(a_pcn), .IorD(a_iord),
    .MemRead(a_mr), .MemWrite(a_mw), .IRWrite(a_irw), .RegWrite(a_rw), .ALUSrcA(a_asa),
    .HIWrite(a_hiw), .LOWrite(a_low), .MultStart(a_ms), .DivStart(a_ds), .RegDst(a_rd),
    .ALUSrcB(a_asb), .ALUOp(a_op), .PCSource(a_pcs), .WBDataSrc(a_wbs),
    .EPCWrite(a_epc), .CauseWrite(a_cw), .ExcCause(a_ec));

  control_unit_exc #(.MEM_WAIT(0), .MD_TIMEOUT(8), .EXC_ENABLE(1'b0)) dut_b (
    .clk(clk), .reset(rst_b), .opcode(opcode), .funct(funct),
    .alu_overflow_in(alu_overflow_in), .mult_done_in(mult_done_in),
    .div_done_in(div_done_in), .div_by_zero_in(div_by_zero_in),
    .PCWrite(b_pcw), .PCWriteCond(b_pcc), .PCWriteCondNeg(b_pcn), .IorD(b_iord),
    .MemRead(b_mr), .MemWrite(b_mw), .IRWrite(b_irw), .RegWrite(b_rw), .ALUSrcA(b_asa),
    .HIWrite(b_hiw), .LOWrite(b_low), .MultStart(b_ms), .DivStart(b_ds), .RegDst(b_rd),
    .ALUSrcB(b_asb), .ALUOp(b_op), .PCSource(b_pcs), .WBDataSrc(b_wbs),
    .EPCWrite(b_epc), .CauseWrite(b_cw), .ExcCause(b_ec));

  // Expected-behaviour tags; each maps to the full control word the spec requires.
  typedef enum int {
    T_END, T_F, T_FL, T_D, T_MA, T_MR, T_SW, T_LWB, T_RADD, T_RSUB, T_RAND, T_RSLT, T_IX,
    T_LUI, T_WBR, T_WBI, T_BEQ, T_BNE, T_J, T_JR, T_JAL, T_MSM, T_MSD, T_IDLE, T_MWD,
    T_MFHI, T_MFLO, T_EXC1, T_EXC2, T_EXC3, T_EXC4
  } tag_t;

  function automatic ctrl_t exp_of(tag_t t);
    ctrl_t c;
    c = '0;
    c.alu_src_a = 1'b1;
    case (t)
      T_F, T_FL: begin
        c.mem_read = 1'b1; c.alu_src_a = 1'b0; c.alu_src_b = 2'b01; c.alu_op = 4'b0010;
        if (t == T_FL) begin c.pc_write = 1'b1; c.ir_write = 1'b1; end
      end
      T_D:        begin c.alu_src_b = 2'b11; c.alu_op = 4'b0010; end
      T_MA, T_IX: begin c.alu_src_b = 2'b10; c.alu_op = 4'b0010; end
      T_MR:       begin c.ior_d = 1'b1; c.mem_read = 1'b1; end
      T_SW:       begin c.ior_d = 1'b1; c.mem_write = 1'b1; end
      T_LWB:      begin c.reg_write = 1'b1; c.wb_data_src = 2'b01; end
      T_RADD:     c.alu_op = 4'b0010;
      T_RSUB:     c.alu_op = 4'b0110;
      T_RAND:     c.alu_op = 4'b0000;
      T_RSLT:     c.alu_op = 4'b0111;
      T_LUI:      begin c.alu_src_b = 2'b10; c.alu_op = 4'b1100; end
      T_WBR:      begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
      T_WBI:      c.reg_write = 1'b1;
      T_BEQ:      begin c.alu_op = 4'b0110; c.pc_source = 3'b001; c.pc_write_cond = 1'b1; end
      T_BNE:      begin c.alu_op = 4'b0110; c.pc_source = 3'b001; c.pc_write_cond_neg = 1'b1; end
      T_J:        begin c.pc_write = 1'b1; c.pc_source = 3'b010; end
      T_JR:       begin c.pc_write = 1'b1; c.pc_source = 3'b011; end
      T_JAL: begin
        c.pc_write = 1'b1; c.reg_write = 1'b1; c.reg_dst = 2'b10; c.pc_source = 3'b010;
        c.alu_src_a = 1'b0; c.alu_src_b = 2'b01;
      end
      T_MSM:      c.mult_start = 1'b1;
      T_MSD:      c.div_start = 1'b1;
      T_MWD:      begin c.hi_write = 1'b1; c.lo_write = 1'b1; end
      T_MFHI:     begin c.reg_write = 1'b1; c.reg_dst = 2'b01; c.wb_data_src = 2'b10; end
      T_MFLO:     begin c.reg_write = 1'b1; c.reg_dst = 2'b01; c.wb_data_src = 2'b11; end
      T_EXC1, T_EXC2, T_EXC3, T_EXC4: begin
        c.epc_write = 1'b1; c.cause_write = 1'b1; c.alu_src_a = 1'b0; c.alu_src_b = 2'b01;
        c.alu_op = 4'b0110; c.pc_write = 1'b1; c.pc_source = 3'b100;
        case (t)
          T_EXC1:  c.exc_cause = 3'b001;
          T_EXC2:  c.exc_cause = 3'b010;
          T_EXC3:  c.exc_cause = 3'b011;
          default: c.exc_cause = 3'b100;
        endcase
      end
      default: ;
    endcase
    return c;
  endfunction

  typedef struct {
    ctrl_t exp;
    bit    which;
    string name;
  } sb_t;
  sb_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  always @(negedge clk) begin : monitor
    sb_t   e;
    ctrl_t act;
    if (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = e.which ? out_b : out_a;
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got ctrl=%h expected ctrl=%h", e.name, act, e.exp);
      end
    end
  end

  // Inputs for the next cycle are staged here and applied just after the clock edge.
  logic       hold_a, hold_b, nx_ovf, nx_dbz;
  logic [5:0] nx_opc, nx_fn;
  bit         cur_which;
  string      cur_name;
  int         cyc;

  task automatic step(tag_t t, logic md = 1'b0, logic dd = 1'b0);
    sb_t e;
    @(posedge clk);
    #1;
    rst_a = hold_a;
    rst_b = hold_b;
    opcode = nx_opc;
    funct = nx_fn;
    alu_overflow_in = nx_ovf;
    div_by_zero_in = nx_dbz;
    mult_done_in = md;
    div_done_in = dd;
    e.exp = exp_of(t);
    e.which = cur_which;
    e.name = $sformatf("%s[%0d]", cur_name, cyc);
    sbq.push_back(e);
    cyc++;
  endtask

  task automatic begin_instr(string name, bit which, logic [5:0] opc, logic [5:0] fn,
                             logic ovf, logic dbz);
    cur_name = name; cur_which = which; cyc = 0;
    nx_opc = opc; nx_fn = fn; nx_ovf = ovf; nx_dbz = dbz;
  endtask

  task automatic fetch_decode();
    if (cur_which) begin
      step(T_FL);
    end else begin
      step(T_F); step(T_F); step(T_FL);
    end
    step(T_D);
  endtask

  typedef struct {
    string      name;
    bit         which;
    logic [5:0] opc, fn;
    logic       ovf, dbz;
    tag_t       tr[6];
  } vec_t;
  vec_t vtab[$];

  task automatic add_vec(string name, bit which, logic [5:0] opc, logic [5:0] fn, logic ovf,
                         logic dbz, tag_t t0, tag_t t1 = T_END, tag_t t2 = T_END,
                         tag_t t3 = T_END, tag_t t4 = T_END, tag_t t5 = T_END);
    vec_t v;
    v.name = name; v.which = which; v.opc = opc; v.fn = fn; v.ovf = ovf; v.dbz = dbz;
    v.tr[0] = t0; v.tr[1] = t1; v.tr[2] = t2; v.tr[3] = t3; v.tr[4] = t4; v.tr[5] = t5;
    vtab.push_back(v);
  endtask

  task automatic run_vec(vec_t v);
    begin_instr(v.name, v.which, v.opc, v.fn, v.ovf, v.dbz);
    fetch_decode();
    for (int i = 0; i < 6; i++) begin
      if (v.tr[i] == T_END) break;
      step(v.tr[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; hold_a = 1'b1; hold_b = 1'b1;
    opcode = '0; funct = '0; alu_overflow_in = 1'b0; mult_done_in = 1'b0;
    div_done_in = 1'b0; div_by_zero_in = 1'b0;
    nx_opc = '0; nx_fn = '0; nx_ovf = 1'b0; nx_dbz = 1'b0;

    //      name        dut opcode     funct      ovf   dbz   trace after DECODE
    add_vec("lw",       0, 6'b100011, 6'b000000, 1'b0, 1'b0, T_MA, T_MR, T_MR, T_MR, T_LWB);
    add_vec("sw",       0, 6'b101011, 6'b000000, 1'b0, 1'b0, T_MA, T_SW, T_SW, T_SW);
    add_vec("add",      0, 6'b000000, 6'b100000, 1'b0, 1'b0, T_RADD, T_WBR);
    add_vec("sub",      0, 6'b000000, 6'b100010, 1'b0, 1'b0, T_RSUB, T_WBR);
    add_vec("and_ovf",  0, 6'b000000, 6'b100100, 1'b1, 1'b0, T_RAND, T_WBR);
    add_vec("slt",      0, 6'b000000, 6'b101010, 1'b0, 1'b0, T_RSLT, T_WBR);
    add_vec("addi",     0, 6'b001000, 6'b000000, 1'b0, 1'b0, T_IX, T_WBI);
    add_vec("addi_ovf", 0, 6'b001000, 6'b000000, 1'b1, 1'b0, T_IX, T_EXC2);
    add_vec("lui",      0, 6'b001111, 6'b000000, 1'b0, 1'b0, T_LUI, T_WBI);
    add_vec("beq",      0, 6'b000100, 6'b000000, 1'b0, 1'b0, T_BEQ);
    add_vec("bne",      0, 6'b000101, 6'b000000, 1'b0, 1'b0, T_BNE);
    add_vec("j",        0, 6'b000010, 6'b000000, 1'b0, 1'b0, T_J);
    add_vec("jal",      0, 6'b000011, 6'b000000, 1'b0, 1'b0, T_JAL);
    add_vec("jr",       0, 6'b000000, 6'b001000, 1'b0, 1'b0, T_JR);
    add_vec("mfhi",     0, 6'b000000, 6'b010000, 1'b0, 1'b0, T_MFHI);
    add_vec("mflo",     0, 6'b000000, 6'b010010, 1'b0, 1'b0, T_MFLO);
    add_vec("add_ovf",  0, 6'b000000, 6'b100000, 1'b1, 1'b0, T_RADD, T_EXC2);
    add_vec("sub_ovf",  0, 6'b000000, 6'b100010, 1'b1, 1'b0, T_RSUB, T_EXC2);
    add_vec("ill_op",   0, 6'b111111, 6'b000000, 1'b0, 1'b0, T_EXC1);
    add_vec("ill_fn",   0, 6'b000000, 6'b111111, 1'b0, 1'b0, T_EXC1);
    add_vec("div_dbz",  0, 6'b000000, 6'b011010, 1'b0, 1'b1, T_IDLE, T_EXC3);
    add_vec("b_add_ovf",  1, 6'b000000, 6'b100000, 1'b1, 1'b0, T_RADD, T_WBR);
    add_vec("b_ill_op",   1, 6'b111111, 6'b000000, 1'b0, 1'b0, T_END);
    add_vec("b_addi_ovf", 1, 6'b001000, 6'b000000, 1'b1, 1'b0, T_IX, T_WBI);

    // Outputs while reset is held are the first FETCH cycle.
    begin_instr("reset_a", 0, '0, '0, 1'b0, 1'b0);
    step(T_F); step(T_F);
    begin_instr("reset_b", 1, '0, '0, 1'b0, 1'b0);
    step(T_FL);

    hold_a = 1'b0;
    foreach (vtab[i]) if (!vtab[i].which) run_vec(vtab[i]);

    begin_instr("mult_done5", 0, 6'b000000, 6'b011000, 1'b0, 1'b0);
    fetch_decode();
    step(T_MSM);
    repeat (4) step(T_IDLE);
    step(T_MWD, 1'b1, 1'b0);

    begin_instr("div_tmo", 0, 6'b000000, 6'b011010, 1'b0, 1'b0);
    fetch_decode();
    step(T_MSD);
    repeat (8) step(T_IDLE);
    step(T_EXC4);

    begin_instr("mult_done_at_tmo", 0, 6'b000000, 6'b011000, 1'b0, 1'b0);
    fetch_decode();
    step(T_MSM);
    repeat (7) step(T_IDLE);
    step(T_MWD, 1'b1, 1'b0);

    begin_instr("lw_rst", 0, 6'b100011, 6'b000000, 1'b0, 1'b0);
    fetch_decode();
    step(T_MA); step(T_MR);
    hold_a = 1'b1;
    step(T_F); step(T_F);
    hold_a = 1'b0;

    begin_instr("mult_rst", 0, 6'b000000, 6'b011000, 1'b0, 1'b0);
    fetch_decode();
    step(T_MSM); step(T_IDLE); step(T_IDLE);
    hold_a = 1'b1;
    step(T_F, 1'b1, 1'b0); step(T_F, 1'b1, 1'b0);
    hold_a = 1'b0;

    begin_instr("after_rst", 0, 6'b000000, 6'b100000, 1'b0, 1'b0);
    step(T_F, 1'b1, 1'b0); step(T_F, 1'b1, 1'b0); step(T_FL); step(T_D);
    step(T_RADD); step(T_WBR);

    hold_a = 1'b1; hold_b = 1'b0;
    foreach (vtab[i]) if (vtab[i].which) run_vec(vtab[i]);

    begin_instr("b_div_tmo", 1, 6'b000000, 6'b011010, 1'b0, 1'b0);
    fetch_decode();
    step(T_MSD);
    repeat (8) step(T_IDLE);
    begin_instr("b_tail", 1, '0, '0, 1'b0, 1'b0);
    step(T_FL);

    @(negedge clk);
    #1;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
